// File: rtl/multicycle_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_pkg: state, opcode and control-field encodings
// shared by the multicycle control unit and its output decoder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multicycle_control_unit_pkg;

  localparam int MCU_STATE_W = 3;

  typedef enum logic [MCU_STATE_W-1:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] A_PC   = 2'd0;
  localparam logic [1:0] A_RS1  = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_BR    = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       is_halted;
  } ctrl_t;

  // Opcodes that proceed from ID into EX; everything else except SYSTEM retires as a NOP.
  function automatic logic needs_ex(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: needs_ex = 1'b1;
      default:                           needs_ex = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_output_decoder.sv
// ---------------------------------------------------------------------------
// mcu_output_decoder: combinational map from FSM state and IR opcode to the
// datapath control word. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcu_output_decoder
  import multicycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
      end
      ST_ID: begin
        ctrl.alu_src_a = A_PC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = ALU_ADD;
        if (opcode == OP_SYSTEM) begin
          ctrl.pc_write = !halt_cond;
        end else if (!needs_ex(opcode)) begin
          ctrl.pc_write = 1'b1;
        end
      end
      ST_EX: begin
        case (opcode)
          OP_REG: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_RS2;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_IMM: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_IMM;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_LUI: begin
            ctrl.alu_src_a = A_ZERO;
            ctrl.alu_src_b = B_IMM;
          end
          OP_AUIPC: begin
            ctrl.alu_src_a = A_PC;
            ctrl.alu_src_b = B_IMM;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_RS2;
            ctrl.alu_op    = ALU_BR;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
          end
          OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALUOUT;
          end
          OP_JALR: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALU;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          ctrl.mem_read = 1'b1;
        end else if (opcode == OP_STORE) begin
          ctrl.mem_write = 1'b1;
          ctrl.pc_write  = mem_ready;
        end
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        ctrl.pc_write  = 1'b1;
      end
      ST_HALT: begin
        ctrl.is_halted = 1'b1;
      end
      default: ;
    endcase
    // Every PC update retires the current instruction.
    ctrl.instr_done = ctrl.pc_write;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit: RV32I multi-cycle sequencing FSM with memory wait
// counter and timeout diagnostic. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int STATE_W  = 3,
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       is_halted,
  output logic       err_timeout
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_d;
  logic [7:0]         wait_cnt;
  logic               timeout_seen;
  logic               waiting;
  logic               timeout_hit;
  ctrl_t              dec_ctrl;
  ctrl_t              ctrl;

  assign state = state_t'(state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_W'(ST_IF);
    end else begin
      state_q <= STATE_W'(state_d);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IF:   if (mem_ready) state_d = ST_ID;
      ST_ID: begin
        if (opcode == OP_SYSTEM) begin
          state_d = halt_cond ? ST_HALT : ST_IF;
        end else if (needs_ex(opcode)) begin
          state_d = ST_EX;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_EX: begin
        case (opcode)
          OP_LOAD, OP_STORE:          state_d = ST_MEM;
          OP_BRANCH, OP_JAL, OP_JALR: state_d = ST_IF;
          default:                    state_d = ST_WB;
        endcase
      end
      ST_MEM:  if (mem_ready) state_d = (opcode == OP_LOAD) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // Counter is zero on entry to IF/MEM because it clears in every non-waiting cycle.
  assign waiting     = ((state == ST_IF) || (state == ST_MEM)) && !mem_ready;
  assign timeout_hit = waiting && (wait_cnt == MAX_WAIT_C) && !timeout_seen;

  always_ff @(posedge clk) begin
    if (reset || !waiting) begin
      wait_cnt     <= '0;
      timeout_seen <= 1'b0;
    end else begin
      if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt == MAX_WAIT_C) timeout_seen <= 1'b1;
    end
  end

  mcu_output_decoder u_decoder (
    .state     (state),
    .opcode    (opcode),
    .bcond     (bcond),
    .halt_cond (halt_cond),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  assign ctrl        = reset ? '0 : dec_ctrl;
  assign err_timeout = !reset && timeout_hit;

  assign pc_write   = ctrl.pc_write;
  assign pc_source  = ctrl.pc_source;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign wb_sel     = ctrl.wb_sel;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign is_halted  = ctrl.is_halted;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit: per-cycle scoreboard of expected control words
// for the multicycle control unit. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

  localparam int MAX_WAIT = 255;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_REG    = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_ECALL  = 7'h73;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       is_halted;
    logic       err_timeout;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       mem_ready;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       instr_done, is_halted, err_timeout;
  logic [1:0] pc_source, wb_sel, alu_src_a, alu_src_b, alu_op;

  ctl_t       obs;
  sb_item_t   sb[$];
  sb_item_t   mon_item;
  int         n_tests = 0;
  int         n_fail  = 0;

  multicycle_control_unit #(.STATE_W(3), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .bcond       (bcond),
    .halt_cond   (halt_cond),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .instr_done  (instr_done),
    .is_halted   (is_halted),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, is_halted, err_timeout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_item = sb.pop_front();
      check_eq(mon_item.tag, 32'(obs), 32'(mon_item.exp));
    end
  end

  function automatic bit known_op(input logic [6:0] op);
    return op inside {OPC_LOAD, OPC_IMM, OPC_AUIPC, OPC_STORE, OPC_REG,
                      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
  endfunction

  function automatic ctl_t e_if(input bit rdy, input bit err);
    ctl_t e = '0;
    e.mem_read    = 1'b1;
    e.ir_write    = rdy;
    e.err_timeout = err;
    return e;
  endfunction

  function automatic ctl_t e_id(input logic [6:0] op, input bit hc);
    ctl_t e = '0;
    e.alu_src_b = 2'd1;
    if ((op == OPC_ECALL && !hc) || (op != OPC_ECALL && !known_op(op))) begin
      e.pc_write   = 1'b1;
      e.instr_done = 1'b1;
    end
    return e;
  endfunction

  function automatic ctl_t e_ex(input logic [6:0] op, input bit bc);
    ctl_t e = '0;
    case (op)
      OPC_REG:             begin e.alu_src_a = 2'd1; e.alu_op = 2'd2; end
      OPC_IMM:             begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.alu_op = 2'd2; end
      OPC_LOAD, OPC_STORE: begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; end
      OPC_LUI:             begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
      OPC_AUIPC:           e.alu_src_b = 2'd1;
      OPC_BRANCH: begin
        e.alu_src_a = 2'd1; e.alu_op = 2'd1;
        e.pc_write = 1'b1; e.instr_done = 1'b1; e.pc_source = bc ? 2'd1 : 2'd0;
      end
      OPC_JAL: begin
        e.reg_write = 1'b1; e.wb_sel = 2'd2;
        e.pc_write = 1'b1; e.instr_done = 1'b1; e.pc_source = 2'd1;
      end
      OPC_JALR: begin
        e.alu_src_a = 2'd1; e.alu_src_b = 2'd1;
        e.reg_write = 1'b1; e.wb_sel = 2'd2;
        e.pc_write = 1'b1; e.instr_done = 1'b1; e.pc_source = 2'd2;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t e_mem(input logic [6:0] op, input bit rdy, input bit err);
    ctl_t e = '0;
    e.i_or_d      = 1'b1;
    e.err_timeout = err;
    if (op == OPC_LOAD) begin
      e.mem_read = 1'b1;
    end else begin
      e.mem_write  = 1'b1;
      e.pc_write   = rdy;
      e.instr_done = rdy;
    end
    return e;
  endfunction

  function automatic ctl_t e_wb(input logic [6:0] op);
    ctl_t e = '0;
    e.reg_write  = 1'b1;
    e.wb_sel     = (op == OPC_LOAD) ? 2'd1 : 2'd0;
    e.pc_write   = 1'b1;
    e.instr_done = 1'b1;
    return e;
  endfunction

  task automatic step(input string tag, input ctl_t e);
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction through its phases with the given memory wait counts.
  task automatic run_instr(input string tag, input logic [6:0] op, input int if_wait,
                           input int mem_wait, input bit bc, input bit hc, input bit hold_rdy);
    opcode    = op;
    bcond     = bc;
    halt_cond = hc;
    for (int i = 0; i <= if_wait; i++) begin
      mem_ready = (i == if_wait);
      step({tag, "/IF"}, e_if(i == if_wait, (i == MAX_WAIT) && (i != if_wait)));
    end
    mem_ready = hold_rdy;
    step({tag, "/ID"}, e_id(op, hc));
    if (op == OPC_ECALL || !known_op(op)) begin
      mem_ready = 1'b0;
      return;
    end
    step({tag, "/EX"}, e_ex(op, bc));
    if (op == OPC_LOAD || op == OPC_STORE) begin
      for (int i = 0; i <= mem_wait; i++) begin
        mem_ready = (i == mem_wait);
        step({tag, "/MEM"}, e_mem(op, i == mem_wait, (i == MAX_WAIT) && (i != mem_wait)));
      end
    end
    if (op inside {OPC_LOAD, OPC_REG, OPC_IMM, OPC_LUI, OPC_AUIPC}) begin
      mem_ready = hold_rdy;
      step({tag, "/WB"}, e_wb(op));
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    ctl_t halted;
    halted           = '0;
    halted.is_halted = 1'b1;

    reset     = 1'b1;
    opcode    = '0;
    bcond     = 1'b0;
    halt_cond = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", '0);
    step("rst1", '0);
    reset     = 1'b0;
    mem_ready = 1'b0;

    run_instr("addi",   OPC_IMM,    0, 0, 1'b0, 1'b0, 1'b1);
    run_instr("lw",     OPC_LOAD,   3, 2, 1'b0, 1'b0, 1'b0);
    run_instr("beq_t",  OPC_BRANCH, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr("beq_nt", OPC_BRANCH, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jalr",   OPC_JALR,   0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("jal",    OPC_JAL,    0, 0, 1'b1, 1'b0, 1'b1);
    run_instr("add",    OPC_REG,    1, 0, 1'b1, 1'b1, 1'b1);
    run_instr("lui",    OPC_LUI,    0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("auipc",  OPC_AUIPC,  0, 0, 1'b0, 1'b0, 1'b0);
    run_instr("sw",     OPC_STORE,  0, 1, 1'b0, 1'b1, 1'b0);
    run_instr("nop",    7'h7F,      0, 0, 1'b1, 1'b1, 1'b0);
    run_instr("ecall0", OPC_ECALL,  0, 0, 1'b1, 1'b0, 1'b0);

    // Reset arrives while a store is waiting in MEM.
    opcode    = OPC_STORE;
    bcond     = 1'b0;
    halt_cond = 1'b0;
    mem_ready = 1'b1;
    step("swr/IF", e_if(1'b1, 1'b0));
    mem_ready = 1'b0;
    step("swr/ID", e_id(OPC_STORE, 1'b0));
    step("swr/EX", e_ex(OPC_STORE, 1'b0));
    step("swr/MEM", e_mem(OPC_STORE, 1'b0, 1'b0));
    reset = 1'b1;
    step("swr/RST", '0);
    reset = 1'b0;
    step("swr/IF2", e_if(1'b0, 1'b0));
    run_instr("addi2", OPC_IMM, 0, 0, 1'b0, 1'b0, 1'b0);

    run_instr("ecall1", OPC_ECALL, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      step("halt", halted);
    end
    reset     = 1'b1;
    mem_ready = 1'b0;
    step("halt_rst", '0);
    reset = 1'b0;

    run_instr("stall", OPC_IMM, 256, 0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
